fact_accel: RTL and testbench

Memory-mapped factorial accelerator on the processor's I/O bus, in the 0x0000_080x window. Consumes the address decoder's `we1` strobe as its write enable and the low address bits for register select. Returns its read data to the bus read mux on `rdsel = 2`. Computes n! for a 4-bit n with an iterative multiply state machine, one multiply per cycle, and reports done/error status for software polling.

---
 rtl/fact_accel.sv | 133 +++++++++++++
 tb/tb_fact_accel.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: computes n! (n <= 12) with one
// 32x4 multiply per cycle, exposing N / GO / STATUS / RESULT registers
// to the I/O bus and a combinational read port.
module fact_accel (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] REG_N      = 2'd0;
  localparam logic [1:0] REG_GO     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  // Largest n whose factorial still fits in 32 bits.
  localparam logic [3:0] N_MAX = 4'd12;

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] prod_q, prod_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        wr_n;
  logic        go_acc;
  logic        n_ok;
  logic        busy;

  // Only the low nibble of N and bit 0 of GO carry meaning.
  logic        unused_wd;
  assign unused_wd = ^wd[31:4];

  assign wr_n   = we && (a == REG_N);
  // A GO request while busy is dropped so the running product is untouched.
  assign go_acc = we && (a == REG_GO) && wd[0] && (state_q != S_BUSY);
  assign n_ok   = (n_q <= N_MAX);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start, overflow short-cut, and countdown completion.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (go_acc) state_d = n_ok ? S_BUSY : S_DONE;
      S_BUSY:         if (cnt_q <= 4'd1) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand latch, iterative multiply, result commit.
  always_comb begin
    n_d      = wr_n ? wd[3:0] : n_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    if (go_acc) begin
      if (n_ok) begin
        prod_d = 32'd1;
        cnt_d  = n_q;
        done_d = 1'b0;
        err_d  = 1'b0;
      end else begin
        result_d = 32'd0;
        done_d   = 1'b1;
        err_d    = 1'b1;
      end
    end else if (state_q == S_BUSY) begin
      if (cnt_q > 4'd1) begin
        // Truncation to 32 bits is harmless: 12! still fits.
        prod_d = prod_q * {28'd0, cnt_q};
        cnt_d  = cnt_q - 4'd1;
      end else begin
        result_d = prod_q;
        done_d   = 1'b1;
        err_d    = 1'b0;
      end
    end
  end

  // Datapath registers; reset aborts any computation and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= 4'd0;
      prod_q   <= 32'd0;
      cnt_q    <= 4'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      n_q      <= n_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Outputs: busy flag and zero-latency read mux.
  always_comb begin
    busy = (state_q == S_BUSY);
    rd   = 32'd0;
    unique case (a)
      REG_N:      rd = {28'd0, n_q};
      REG_GO:     rd = {31'd0, busy};
      REG_STATUS: rd = {30'd0, err_q, done_q};
      REG_RESULT: rd = result_q;
      default:    rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: directed scenarios plus randomized
// runs with bus noise, compared against a register-level reference model.
module tb_fact_accel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [1:0]  a   = 2'd0;
  logic [31:0] wd  = 32'd0;
  logic [31:0] rd;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of software-visible registers.
  logic [3:0]  m_n;
  logic [31:0] m_result;
  logic        m_done;
  logic        m_err;

  fact_accel dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact(input int n);
    longint p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  function automatic int latency(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Combinational read with we low; called away from the clock edge.
  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    we = 1'b0;
    a  = addr;
    #1;
    data = rd;
  endtask

  // One-cycle write: drive at negedge, capture at the next posedge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (addr == 2'd0) m_n = data[3:0];
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    bus_read(2'd0, v); check({tag, ".N"},      v, {28'd0, m_n});
    bus_read(2'd1, v); check({tag, ".BUSY"},   v, 32'd0);
    bus_read(2'd2, v); check({tag, ".STATUS"}, v, {30'd0, m_err, m_done});
    bus_read(2'd3, v); check({tag, ".RESULT"}, v, m_result);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    m_n = 4'd0; m_result = 32'd0; m_done = 1'b0; m_err = 1'b0;
  endtask

  // Issue GO with the model's current n and follow the run cycle by cycle.
  // With noise set, random bus writes are driven during the busy cycles.
  task automatic run_go(input string tag, input bit noise);
    int          n0;
    int          lat;
    logic [31:0] v;
    n0 = int'(m_n);
    bus_write(2'd1, 32'd1);                // edge k
    if (n0 >= 13) begin
      @(posedge clk); #1;                  // edge k+1
      m_result = 32'd0; m_done = 1'b1; m_err = 1'b1;
      check_all({tag, ".ovf"});
      return;
    end
    lat = latency(n0);
    bus_read(2'd1, v); check({tag, ".busy_k"}, v, 32'd1);
    bus_read(2'd2, v); check({tag, ".status_k"}, v, 32'd0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (noise && ($urandom_range(0, 1) == 1)) begin
        we = 1'b1;
        a  = 2'($urandom_range(0, 3));
        wd = $urandom;
        if (a == 2'd0) m_n = wd[3:0];
      end
      @(posedge clk); #1;                  // edge k+i
      we = 1'b0;
      if (i < lat) begin
        bus_read(2'd1, v);
        check({tag, ".busy"}, v, 32'd1);
        bus_read(2'd3, v);
        check({tag, ".result_hold"}, v, m_result);
      end else begin
        m_result = fact(n0); m_done = 1'b1; m_err = 1'b0;
        check_all({tag, ".done"});
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int          n_rand;

    // Reset state.
    do_reset(2);
    check_all("reset");

    // n=5.
    bus_write(2'd0, 32'd5);
    run_go("n5", 1'b0);

    // n=0 and n=1.
    bus_write(2'd0, 32'd0);
    run_go("n0", 1'b0);
    bus_write(2'd0, 32'd1);
    run_go("n1", 1'b0);

    // n=12 then overflow n=13.
    bus_write(2'd0, 32'd12);
    run_go("n12", 1'b0);
    check("n12.value", m_result, 32'h1C8C_FC00);
    bus_write(2'd0, 32'd13);
    run_go("n13", 1'b0);

    // GO with wd[0]=0 is a no-op; we low changes nothing.
    bus_write(2'd1, 32'hFFFF_FFFE);
    repeat (2) @(posedge clk);
    #1;
    check_all("go0");
    @(negedge clk);
    we = 1'b0; a = 2'd0; wd = 32'h0000_0007;
    @(posedge clk); #1;
    check_all("we_low");

    // n=6 with N and GO written mid-run.
    bus_write(2'd0, 32'd6);
    bus_write(2'd1, 32'd1);                // edge k
    @(posedge clk); #1;                    // edge k+1
    bus_write(2'd0, 32'd3);                // edge k+2
    bus_write(2'd1, 32'd1);                // edge k+3, ignored
    repeat (2) @(posedge clk);             // edge k+5
    #1;
    bus_read(2'd1, v); check("intf.busy_k5", v, 32'd1);
    @(posedge clk); #1;                    // edge k+6
    m_result = 32'd720; m_done = 1'b1; m_err = 1'b0;
    check_all("intf.done");
    run_go("intf.n3", 1'b0);

    // n=10 aborted by reset at edge k+4, then n=4.
    bus_write(2'd0, 32'd10);
    bus_write(2'd1, 32'd1);                // edge k
    repeat (3) @(posedge clk);             // edge k+3
    do_reset(1);                           // rst sampled at edge k+4
    check_all("abort");
    repeat (8) @(posedge clk);
    #1;
    check_all("abort.idle");
    bus_write(2'd0, 32'd4);
    run_go("after_abort", 1'b0);

    // Randomized runs with bus noise during computation.
    for (int t = 0; t < 25; t++) begin
      n_rand = $urandom_range(0, 15);
      bus_write(2'd0, 32'(n_rand) | ($urandom & 32'hFFFF_FFF0));
      run_go($sformatf("rand%0d_n%0d", t, n_rand), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: the stimulus is bounded, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
